// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: single-outstanding fetch FSM feeding a DEPTH-entry instruction queue.
// Define IFU_PREFETCH_STATIC_PREDICT_EN to follow predicted-taken branches and jumps while fetching.
module ifu_prefetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_pred_taken,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int             PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL  = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_STALL} state_t;

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] redirect_aligned;
    logic [31:0]       q_inst [DEPTH];
    logic [ADDR_W-1:0] q_pc   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    count;
    logic [PTR_W:0]    count_next;
    logic              enq;
    logic              deq;

    assign pc_plus4         = fetch_pc + ADDR_W'(4);
    assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

    // A redirect wins over both queue ports in the same cycle.
    assign enq = (state == S_WAIT) & mem_rvalid & ~redirect;
    assign deq = inst_valid & inst_ready & ~redirect;

    always_comb begin
        count_next = count;
        case ({enq, deq})
            2'b10:   count_next = count + (PTR_W+1)'(1);
            2'b01:   count_next = count - (PTR_W+1)'(1);
            default: count_next = count;
        endcase
    end

`ifdef IFU_PREFETCH_STATIC_PREDICT_EN
    logic [5:0]         opcode;
    logic signed [33:0] br_off;
    logic [ADDR_W-1:0]  jmp_mask;
    logic               pred_bit;
    logic [DEPTH-1:0]   q_pred;

    assign opcode   = mem_rdata[31:26];
    assign br_off   = {{16{mem_rdata[15]}}, mem_rdata[15:0], 2'b00};
    // Jump keeps the upper bits of pc+4 above bit 27 and replaces the rest.
    assign jmp_mask = ADDR_W'(28'hFFF_FFFF);

    always_comb begin
        pred_bit = 1'b0;
        next_pc  = pc_plus4;
        if ((opcode == 6'h04 || opcode == 6'h05) && mem_rdata[15]) begin
            pred_bit = 1'b1;
            next_pc  = pc_plus4 + ADDR_W'(br_off);
        end else if (opcode == 6'h02) begin
            pred_bit = 1'b1;
            next_pc  = (pc_plus4 & ~jmp_mask) | (ADDR_W'({mem_rdata[25:0], 2'b00}) & jmp_mask);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_pred[wr_ptr] <= pred_bit;
        end
    end

    assign inst_pred_taken = inst_valid & q_pred[rd_ptr];
`else
    assign next_pc         = pc_plus4;
    assign inst_pred_taken = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (enq) begin
            q_inst[wr_ptr] <= mem_rdata;
            q_pc[wr_ptr]   <= fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_REQ;
            fetch_pc <= RESET_PC & ~ADDR_W'(3);
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
                if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count_next;
            end

            case (state)
                S_REQ: begin
                    if (redirect) begin
                        fetch_pc <= redirect_aligned;
                        state    <= mem_ack ? S_DROP : S_REQ;
                    end else if (mem_ack) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        fetch_pc <= redirect_aligned;
                        state    <= mem_rvalid ? S_REQ : S_DROP;
                    end else if (mem_rvalid) begin
                        fetch_pc <= next_pc;
                        state    <= (count_next == FULL) ? S_STALL : S_REQ;
                    end
                end
                S_DROP: begin
                    if (redirect) fetch_pc <= redirect_aligned;
                    if (mem_rvalid) state <= S_REQ;
                end
                S_STALL: begin
                    if (redirect) begin
                        fetch_pc <= redirect_aligned;
                        state    <= S_REQ;
                    end else if (count != FULL) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    // Request is suppressed combinationally while reset is held so it is low throughout reset.
    assign mem_req    = (state == S_REQ) & ~reset;
    assign mem_addr   = fetch_pc;
    assign inst_valid = (count != '0);
    assign inst       = q_inst[rd_ptr];
    assign inst_pc    = q_pc[rd_ptr];

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: directed scenarios plus randomized traffic against an instruction-stream scoreboard.
module tb_ifu_prefetch;

`ifdef IFU_PREFETCH_STATIC_PREDICT_EN
    localparam bit PRED_EN = 1'b1;
`else
    localparam bit PRED_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_pred_taken;
    logic        inst_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    logic        u8_mem_req;
    logic [7:0]  u8_mem_addr;
    logic        u8_mem_ack = 1'b0;
    logic        u8_mem_rvalid = 1'b0;
    logic [31:0] u8_mem_rdata = 32'h2000_0000;
    logic        u8_inst_valid;
    logic [31:0] u8_inst;
    logic [7:0]  u8_inst_pc;
    logic        u8_inst_pred;
    logic        u8_inst_ready = 1'b0;
    logic        u8_redirect = 1'b0;
    logic [7:0]  u8_redirect_pc = '0;

    always #5 clk = ~clk;

    ifu_prefetch #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_pred_taken(inst_pred_taken), .inst_ready(inst_ready),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    ifu_prefetch #(.ADDR_W(8), .DEPTH(4), .RESET_PC(8'hFC)) dut8 (
        .clk(clk), .reset(reset), .mem_req(u8_mem_req), .mem_addr(u8_mem_addr),
        .mem_ack(u8_mem_ack), .mem_rvalid(u8_mem_rvalid), .mem_rdata(u8_mem_rdata),
        .inst_valid(u8_inst_valid), .inst(u8_inst), .inst_pc(u8_inst_pc),
        .inst_pred_taken(u8_inst_pred), .inst_ready(u8_inst_ready),
        .redirect(u8_redirect), .redirect_pc(u8_redirect_pc)
    );

    int          checks = 0;
    int          errors = 0;
    int          consumed = 0;
    int          ack_pct = 100;
    int          rv_min = 0;
    int          rv_max = 0;
    bit          outst = 1'b0;
    int          out_delay = 0;
    logic [31:0] out_addr = '0;
    logic [31:0] exp_pc = '0;
    logic [31:0] fetch_q[$];
    logic [31:0] cons_pcs[$];

    // Memory image: low region is plain ALU-like words, 0x40 holds a backward branch to itself.
    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'h40) return 32'h1000_FFFF;
        if (a < 32'h40) return 32'h2000_0000 | a;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic bit exp_pred(input logic [31:0] w);
        return PRED_EN && ((((w[31:26] == 6'h04) || (w[31:26] == 6'h05)) && w[15]) || (w[31:26] == 6'h02));
    endfunction

    function automatic logic [31:0] exp_next(input logic [31:0] pc, input logic [31:0] w);
        logic [31:0] p4;
        p4 = pc + 32'd4;
        if (PRED_EN && ((w[31:26] == 6'h04) || (w[31:26] == 6'h05)) && w[15])
            return p4 + {{14{w[15]}}, w[15:0], 2'b00};
        if (PRED_EN && (w[31:26] == 6'h02))
            return {p4[31:28], w[25:0], 2'b00};
        return p4;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive memory/decode inputs, score any consumption, advance the memory model.
    task automatic tick(input bit rdy, input bit redir, input logic [31:0] rpc);
        bit          do_ack, do_rv, cons, hold;
        logic [31:0] w, h_pc, h_inst;
        do_ack = mem_req && !outst && ($urandom_range(99) < ack_pct);
        do_rv  = outst && (out_delay == 0);
        mem_ack     = do_ack;
        mem_rvalid  = do_rv;
        mem_rdata   = do_rv ? word(out_addr) : $urandom;
        inst_ready  = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        if (mem_req) chk("addr_align", {62'd0, mem_addr[1:0]}, 64'd0);
        cons = inst_valid && rdy && !redir && !reset;
        hold = inst_valid && !rdy && !redir && !reset;
        h_pc = inst_pc;
        h_inst = inst;
        if (cons) begin
            w = word(exp_pc);
            chk("sb_pc", inst_pc, exp_pc);
            chk("sb_inst", inst, w);
            chk("sb_pred", inst_pred_taken, exp_pred(w));
            cons_pcs.push_back(inst_pc);
            exp_pc = exp_next(exp_pc, w);
            consumed++;
        end
        if (redir && !reset) exp_pc = rpc & ~32'd3;
        if (do_ack) fetch_q.push_back(mem_addr);
        @(posedge clk);
        #1;
        if (do_rv) outst = 1'b0;
        else if (outst) out_delay--;
        if (do_ack) begin
            outst = 1'b1;
            out_addr = fetch_q[fetch_q.size()-1];
            out_delay = $urandom_range(rv_max, rv_min);
        end
        if (hold) begin
            chk("hold_valid", inst_valid, 1);
            chk("hold_pc", inst_pc, h_pc);
            chk("hold_inst", inst, h_inst);
        end
        if (redir && !reset) chk("redirect_flush", inst_valid, 0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick(0, 0, 32'h0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_pred", inst_pred_taken, 0);
        chk("rst_u8_mem_req", u8_mem_req, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_mem_req", mem_req, 1);
        chk("post_rst_addr", mem_addr, 32'h0);
        exp_pc = 32'h0;
        fetch_q.delete();
        cons_pcs.delete();
    endtask

    initial begin
        bit seen;

        // Sequential fetch, full-rate memory, always-ready decode; 8-bit instance wraps from 0xFC.
        do_reset(3);
        chk("u8_first_addr", u8_mem_addr, 8'hFC);
        chk("u8_first_req", u8_mem_req, 1);
        u8_mem_ack = 1'b1;
        tick(1, 0, 32'h0);
        u8_mem_ack = 1'b0;
        u8_mem_rvalid = 1'b1;
        tick(1, 0, 32'h0);
        u8_mem_rvalid = 1'b0;
        chk("u8_wrap_addr", u8_mem_addr, 8'h00);
        chk("u8_wrap_req", u8_mem_req, 1);
        chk("u8_head_valid", u8_inst_valid, 1);
        chk("u8_head_pc", u8_inst_pc, 8'hFC);
        chk("u8_head_inst", u8_inst, 32'h2000_0000);
        chk("u8_head_pred", u8_inst_pred, 0);
        repeat (12) tick(1, 0, 32'h0);
        chk("seq_fetch_cnt", fetch_q.size() >= 4, 1);
        chk("seq_cons_cnt", cons_pcs.size() >= 4, 1);
        for (int i = 0; i < 4; i++) begin
            if (i < fetch_q.size()) chk("seq_mem_addr", fetch_q[i], 32'(4 * i));
            if (i < cons_pcs.size()) chk("seq_inst_pc", cons_pcs[i], 32'(4 * i));
        end

        // Decode stalled: exactly DEPTH fetches, then one dequeue releases the next fetch at 16.
        do_reset(2);
        repeat (20) tick(0, 0, 32'h0);
        chk("full_fetch_cnt", fetch_q.size(), 4);
        chk("full_mem_req", mem_req, 0);
        chk("full_head_pc", inst_pc, 32'h0);
        chk("full_head_inst", inst, word(32'h0));
        tick(1, 0, 32'h0);
        chk("deq_head_pc", inst_pc, 32'h4);
        seen = 1'b0;
        for (int i = 0; i < 3 && !seen; i++) begin
            if (mem_req) seen = 1'b1;
            else tick(0, 0, 32'h0);
        end
        chk("stall_release", seen, 1);
        chk("release_addr", mem_addr, 32'h10);

        // Redirect while waiting on memory: response is dropped, fetch resumes at 0x100.
        rv_min = 2;
        rv_max = 2;
        tick(0, 0, 32'h0);
        chk("wait_acked", outst, 1);
        tick(0, 1, 32'h100);
        chk("drop_mem_req", mem_req, 0);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (mem_req) seen = 1'b1;
            else tick(0, 0, 32'h0);
        end
        chk("drop_resume", seen, 1);
        chk("drop_new_addr", mem_addr, 32'h100);
        chk("drop_queue_empty", inst_valid, 0);
        chk("drop_outstanding", outst, 0);
        repeat (10) tick(1, 0, 32'h0);

        // Branch word 0x1000FFFF at 0x40 (redirect low bits ignored).
        rv_min = 0;
        rv_max = 0;
        tick(0, 1, 32'h41);
        fetch_q.delete();
        for (int i = 0; i < 20 && fetch_q.size() < 2; i++) tick(0, 0, 32'h0);
        chk("br_fetch_cnt", fetch_q.size() >= 2, 1);
        if (fetch_q.size() >= 2) begin
            chk("br_first_addr", fetch_q[0], 32'h40);
            chk("br_next_addr", fetch_q[1], PRED_EN ? 32'h40 : 32'h44);
        end
        chk("br_head_pc", inst_pc, 32'h40);
        chk("br_head_inst", inst, 32'h1000_FFFF);
        chk("br_head_pred", inst_pred_taken, PRED_EN);

        // Reset with a response still in flight: it must be ignored afterwards.
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (mem_req && !outst) seen = 1'b1;
            else tick(1, 0, 32'h0);
        end
        chk("mid_rst_req", seen, 1);
        rv_min = 3;
        rv_max = 3;
        tick(0, 0, 32'h0);
        chk("mid_rst_acked", outst, 1);
        do_reset(2);
        tick(0, 0, 32'h0);
        tick(0, 0, 32'h0);
        chk("stale_rsp_ignored", inst_valid, 0);
        chk("stale_still_req", mem_req, 1);
        chk("stale_addr", mem_addr, 32'h0);

        // Randomized traffic against the stream scoreboard.
        ack_pct = 70;
        rv_min = 0;
        rv_max = 3;
        for (int i = 0; i < 1500; i++) begin
            tick($urandom_range(99) < 70, $urandom_range(99) < 3, $urandom & 32'hFFF);
        end
        chk("progress", consumed > 200, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu_prefetch.md
IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 Parameter ADDR_W, default 32, meaning PC and memory address width in bits.
REQ-002 Parameter DEPTH, default 4, meaning instruction queue entries (power of two, 2..16).
REQ-003 Parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 mem_req  out  1  fetch request valid; held high until mem_ack.
REQ-007 mem_addr  out  ADDR_W  fetch byte address; always a multiple of 4.
REQ-008 mem_ack  in  1  memory accepted request this cycle.
REQ-009 mem_rvalid  in  1  read data valid; exactly one per accepted request, at least 1 cycle after mem_ack.
REQ-010 mem_rdata  in  32  instruction word.
REQ-011 inst_valid  out  1  queue head valid.
REQ-012 inst  out  32  queue head instruction.
REQ-013 inst_pc  out  ADDR_W  address of queue head instruction.
REQ-014 inst_pred_taken  out  1  queue head was predicted taken.
REQ-015 inst_ready  in  1  decode consumes head when inst_valid and inst_ready are both high.
REQ-016 redirect  in  1  resolved-branch or jump flush.
REQ-017 redirect_pc  in  ADDR_W  new fetch address; bits [1:0] ignored and treated as 0.

Function
REQ-018 FSM states are REQ, WAIT, DROP and STALL; at most one request outstanding.
REQ-019 In REQ, mem_req is 1 and mem_addr is fetch_pc; on mem_ack the FSM goes to WAIT.
REQ-020 In WAIT, on mem_rvalid the word is enqueued with its PC, fetch_pc advances, and the FSM goes to REQ, or to STALL if the queue then holds DEPTH entries.
REQ-021 In STALL, mem_req is 0; the FSM returns to REQ in the cycle after occupancy drops below DEPTH.
REQ-022 Sequential next PC is fetch_pc+4 modulo 2^ADDR_W; wrap-around from the top address to 0 is legal and is not clamped.
REQ-023 Enqueue-to-head latency: an entry written on an mem_rvalid edge is visible on inst_* in the next cycle.
REQ-024 The queue supports enqueue and dequeue in the same cycle when full; occupancy is then unchanged.
REQ-025 inst, inst_pc and inst_pred_taken are stable while inst_valid=1 and inst_ready=0.
REQ-026 A redirect empties the queue, so inst_valid=0 in the following cycle, and fetch_pc becomes redirect_pc.
REQ-027 Redirect in REQ without mem_ack: stay in REQ; mem_addr is redirect_pc in the next cycle.
REQ-028 Redirect in REQ with mem_ack, or in WAIT without mem_rvalid: go to DROP.
REQ-029 Redirect in WAIT with mem_rvalid: the response is discarded and not enqueued; go to REQ.
REQ-030 In DROP, mem_req is 0; the next mem_rvalid is discarded and the FSM goes to REQ.
REQ-031 Redirect in STALL: go to REQ.
REQ-032 Redirect has priority over a same-cycle enqueue and over a same-cycle dequeue.

Reset
REQ-033 While reset=1: FSM enters REQ, fetch_pc=RESET_PC, queue is empty, mem_req=0, inst_valid=0, inst_pred_taken=0.
REQ-034 mem_req=1 with mem_addr=RESET_PC in the first cycle after reset deasserts.
REQ-035 A response arriving after a mid-transaction reset is ignored; after reset the FSM is in REQ, not WAIT.

Configuration
REQ-036 Macro IFU_PREFETCH_STATIC_PREDICT_EN selects static branch prediction.
REQ-037 With the macro defined: an enqueued word with opcode [31:26] equal to 6'h04 or 6'h05 and bit [15]=1 sets next fetch_pc to pc+4+(sext(imm16)<<2) and sets the entry's pred_taken bit.
REQ-038 With the macro defined: an enqueued word with opcode 6'h02 sets next fetch_pc to {pc+4[ADDR_W-1:28], addr26, 2'b00} and sets pred_taken.
REQ-039 Without the macro: next fetch_pc is always pc+4 and inst_pred_taken is constant 0.

Verification
REQ-040 Reset, then mem_ack and mem_rvalid each cycle after the request, inst_ready=1 -> mem_addr sequence 0,4,8,12; inst_pc follows the same sequence.
REQ-041 inst_ready=0 with DEPTH=4 -> exactly 4 fetches, then mem_req=0; one dequeue -> mem_req=1 in the cycle after, address 16.
REQ-042 redirect to 0x100 while in WAIT -> the next response is dropped, the queue is empty, and the next mem_addr is 0x100.
REQ-043 ADDR_W=8, fetch_pc=0xFC -> the next fetch address is 0x00.
REQ-044 Macro defined, word 0x1000FFFF fetched at 0x40 -> next mem_addr is 0x40, inst_pred_taken=1.
REQ-045 Macro undefined, same word -> next mem_addr is 0x44, inst_pred_taken=0.
